// File: rtl/inv_cipher_iter.sv
// Iterative AES inverse cipher: one InvCipher round per clock, valid/ready on
// both sides. Round keys come from a combinational key expansion of the
// registered key.

package inv_cipher_pkg;
    typedef logic [0:127] block_t;

    // Forward S-box, entry x at bits [8x +: 8] (used by the key schedule)
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Inverse S-box, entry x at bits [8x +: 8]
    localparam logic [0:2047] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{b, 3'b000} +: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo 0x11b
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul_9(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic logic [7:0] mul_b(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] mul_d(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic logic [7:0] mul_e(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    // Row r of the column-major state rotates right by r bytes
    function automatic block_t inv_shift_rows(input block_t s);
        block_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(4*c + r) +: 8] = s[8*(4*((c - r + 4) % 4) + r) +: 8];
            end
        end
        return o;
    endfunction

    function automatic block_t inv_sub_bytes(input block_t s);
        block_t o;
        o = '0;
        for (int b = 0; b < 16; b++) begin
            o[8*b +: 8] = inv_sbox(s[8*b +: 8]);
        end
        return o;
    endfunction

    // Each column times {0e,0b,0d,09}, built from xtime chains only
    function automatic block_t inv_mix_columns(input block_t s);
        block_t     o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c      +: 8];
            a1 = s[32*c + 8  +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            o[32*c      +: 8] = mul_e(a0) ^ mul_b(a1) ^ mul_d(a2) ^ mul_9(a3);
            o[32*c + 8  +: 8] = mul_9(a0) ^ mul_e(a1) ^ mul_b(a2) ^ mul_d(a3);
            o[32*c + 16 +: 8] = mul_d(a0) ^ mul_9(a1) ^ mul_e(a2) ^ mul_b(a3);
            o[32*c + 24 +: 8] = mul_b(a0) ^ mul_d(a1) ^ mul_9(a2) ^ mul_e(a3);
        end
        return o;
    endfunction
endpackage

// Combinational FIPS-197 key expansion; round key r is w[128r +: 128]
module keyexpansion
    import inv_cipher_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic [0:32*Nk-1]       key,
    output logic [0:128*(Nr+1)-1]  w
);
    localparam int NW = 4 * (Nr + 1);

    // Expand the key word by word; each word depends only on earlier ones
    always_comb begin : expand
        logic [31:0] wk [NW];
        logic [31:0] temp;
        logic [7:0]  rc;
        // NOTE: every variable gets a value before any branch, so no latch is inferred.
        rc   = 8'h01;
        temp = '0;
        w    = '0;
        for (int i = 0; i < Nk; i++) begin
            wk[i] = key[32*i +: 32];
        end
        for (int i = Nk; i < NW; i++) begin
            temp = wk[i-1];
            if (i % Nk == 0) begin
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h000000};
                rc   = xtime(rc);
            end else if (Nk > 6 && i % Nk == 4) begin
                temp = sub_word(temp);
            end
            wk[i] = wk[i-Nk] ^ temp;
        end
        for (int i = 0; i < NW; i++) begin
            w[32*i +: 32] = wk[i];
        end
    end
endmodule

module inv_cipher_iter
    import inv_cipher_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:127]     in,
    input  logic [0:32*Nk-1] key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:127]     out
);
    typedef enum logic [1:0] {IDLE, INIT, ROUND, DONE} state_t;

    localparam logic [3:0] NR_L  = 4'(Nr);
    localparam logic [3:0] NR_M1 = 4'(Nr - 1);

    state_t                 st, st_nxt;
    block_t                 state_q;
    logic [0:32*Nk-1]       key_q;
    logic [3:0]             round_q;
    logic [0:128*(Nr+1)-1]  w;
    logic [3:0]             rk_sel;
    block_t                 rk, rnd_pre, rnd_mix;

    keyexpansion #(.Nk(Nk), .Nr(Nr)) u_keyexp (
        .key (key_q),
        .w   (w)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) st <= IDLE;
        else     st <= st_nxt;
    end

    // FSM next-state logic
    always_comb begin
        st_nxt = st;
        case (st)
            IDLE:    if (in_valid) st_nxt = INIT;
            INIT:    st_nxt = ROUND;
            ROUND:   if (round_q == 4'd0) st_nxt = DONE;
            DONE:    if (out_ready) st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    // FSM outputs: handshakes are pure state decodes, out is zero unless DONE
    always_comb begin
        in_ready  = (st == IDLE);
        out_valid = (st == DONE);
        out       = (st == DONE) ? state_q : '0;
    end

    // Round datapath: INIT whitens with w[Nr], ROUND uses w[round]
    always_comb begin
        rk_sel  = (st == INIT) ? NR_L : round_q;
        rk      = w[{rk_sel, 7'd0} +: 128];
        rnd_pre = inv_sub_bytes(inv_shift_rows(state_q)) ^ rk;
        rnd_mix = inv_mix_columns(rnd_pre);
    end

    // State, key and round counter updates
    always_ff @(posedge clk) begin
        // NOTE: the datapath registers are reset as well, so a transaction aborted by reset leaves key_q and the counter at zero.
        if (rst) begin
            state_q <= '0;
            key_q   <= '0;
            round_q <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register sees the pre-edge value of state_q and round_q.
            case (st)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= in;
                        key_q   <= key;
                    end
                end
                INIT: begin
                    state_q <= state_q ^ rk;
                    round_q <= NR_M1;
                end
                ROUND: begin
                    if (round_q != 4'd0) begin
                        state_q <= rnd_mix;
                        round_q <= round_q - 4'd1;
                    end else begin
                        state_q <= rnd_pre;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_inv_cipher_iter.sv
// Scoreboard bench for inv_cipher_iter: AES-128/192/256 instances, directed
// FIPS-197 / SP800-38A vectors, backpressure, mid-round reset, back-to-back.

module tb_inv_cipher_iter;

    typedef struct {
        int           lane;
        logic [0:127] pt;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   in_valid;
    logic [2:0]   out_ready;
    wire  [2:0]   in_ready;
    wire  [2:0]   out_valid;
    logic [0:127] din;
    logic [0:255] key_all;
    wire  [0:127] dout [3];

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_push = 0;
    int   n_pop = 0;
    int   last_acc = 0;
    int   acc_edge [3];
    exp_t exp_q [$];

    localparam logic [0:127] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] P2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] C3  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [0:127] P3  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [0:191] K24 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [0:127] C24 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [0:255] K32 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [0:127] C32 = 128'h8ea2b7ca516745bfeafc49904b496089;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    inv_cipher_iter #(.Nk(4), .Nr(10)) u_dut128 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in(din), .key(key_all[0:127]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out(dout[0])
    );

    inv_cipher_iter #(.Nk(6), .Nr(12)) u_dut192 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in(din), .key(key_all[0:191]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out(dout[1])
    );

    inv_cipher_iter #(.Nk(8), .Nr(14)) u_dut256 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in(din), .key(key_all),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out(dout[2])
    );

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Present one block on a lane; called just after a rising edge.
    task automatic send(input int lane, input logic [0:127] ct, input logic [0:255] k,
                        input logic [0:127] pt, input bit expect_out, input bit hold);
        bit got = 1'b0;
        din = ct;
        key_all = k;
        in_valid[lane] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready[lane]) begin
                got = 1'b1;
                break;
            end
        end
        check($sformatf("accept_lane%0d", lane), got, 1);
        if (got && expect_out) begin
            exp_q.push_back('{lane: lane, pt: pt});
            n_push++;
        end
        @(posedge clk);
        #1;
        last_acc = cyc;
        if (!hold) in_valid[lane] = 1'b0;
    endtask

    // Wait until every expected block has been seen; returns just after a rising edge.
    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int lane, input int max_cycles);
        bit seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (out_valid[lane]) begin
                seen = 1'b1;
                break;
            end
        end
        check($sformatf("wait_out_lane%0d", lane), seen, 1);
    endtask

    // Monitor: latency of each output and scoreboard compare on every output handshake
    initial begin : monitor
        exp_t       e;
        logic [2:0] prev_ov;
        prev_ov = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ov = '0;
            end else begin
                for (int l = 0; l < 3; l++) begin
                    if (in_valid[l] && in_ready[l]) acc_edge[l] = cyc + 1;
                    if (out_valid[l] && !prev_ov[l])
                        check($sformatf("latency_lane%0d", l), cyc - acc_edge[l], 10 + 2*l + 1);
                    if (out_valid[l] && out_ready[l]) begin
                        if (exp_q.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL unexpected_out lane%0d: got %h, no block outstanding", l, dout[l]);
                        end else begin
                            e = exp_q.pop_front();
                            n_pop++;
                            check("out_lane", l, e.lane);
                            check($sformatf("plaintext_lane%0d", l), dout[l], e.pt);
                        end
                    end
                    prev_ov[l] = out_valid[l];
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: time limit reached, %0d vectors applied", n_vec);
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin : stim
        int a0, a1, a2;
        rst = 1'b1;
        in_valid = '0;
        out_ready = '0;
        din = '0;
        key_all = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state on every instance
        @(negedge clk);
        for (int l = 0; l < 3; l++) begin
            check($sformatf("rst_in_ready%0d", l), in_ready[l], 1);
            check($sformatf("rst_out_valid%0d", l), out_valid[l], 0);
            check($sformatf("rst_out%0d", l), dout[l], 0);
        end
        @(posedge clk);
        #1;
        out_ready = 3'b111;

        // AES-128 vectors
        send(0, C1, {K1, 128'h0}, P1, 1'b1, 1'b0);
        drain(60);
        send(0, C2, {K2, 128'h0}, P2, 1'b1, 1'b0);
        drain(60);

        // AES-192 and AES-256
        send(1, C24, {K24, 64'h0}, P1, 1'b1, 1'b0);
        drain(60);
        send(2, C32, K32, P1, 1'b1, 1'b0);
        drain(60);

        // Backpressure with in/key churn while stalled
        out_ready[0] = 1'b0;
        send(0, C1, {K1, 128'h0}, P1, 1'b1, 1'b0);
        wait_out(0, 40);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            din = {$urandom, $urandom, $urandom, $urandom};
            key_all = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            in_valid[0] = i[0];
            @(negedge clk);
            check("stall_out", dout[0], P1);
            check("stall_out_valid", out_valid[0], 1);
            check("stall_in_ready", in_ready[0], 0);
        end
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_stall_in_ready", in_ready[0], 1);
        check("post_stall_out_valid", out_valid[0], 0);
        @(posedge clk);
        #1;

        // Reset while round counter holds 5
        send(0, C1, {K1, 128'h0}, P1, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", out_valid[0], 0);
        check("abort_out", dout[0], 0);
        check("abort_in_ready", in_ready[0], 1);
        @(posedge clk);
        #1;
        send(0, C1, {K1, 128'h0}, P1, 1'b1, 1'b0);
        drain(60);

        // Back-to-back, in_valid held high
        send(0, C1, {K1, 128'h0}, P1, 1'b1, 1'b1);
        a0 = last_acc;
        send(0, C2, {K2, 128'h0}, P2, 1'b1, 1'b1);
        a1 = last_acc;
        send(0, C3, {K2, 128'h0}, P3, 1'b1, 1'b0);
        a2 = last_acc;
        check("b2b_gap1", a1 - a0, 13);
        check("b2b_gap2", a2 - a1, 13);
        drain(60);

        check("pushed_vs_popped", n_pop, n_push);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inv_cipher_iter.md
Name: inv_cipher_iter

Overview:
Iterative AES inverse cipher (FIPS-197 InvCipher) that decrypts one 128-bit block per transaction. It computes one round per clock and uses a valid/ready handshake on both input and output. It is the decrypt counterpart of the combinational cipher. The round keys come from an internal instance of the existing keyexpansion module, fed from a registered copy of the key.

Parameters:
Nk, 4, key length in 32-bit words (4/6/8 for AES-128/192/256); key width Nkb = 32*Nk
Nr, 10, number of rounds (10/12/14 paired with Nk 4/6/8); other pairings are unsupported

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  ciphertext and key presented
in_ready  output  1  block can accept a new transaction
in  input  128  ciphertext block, big-endian [0:127]
key  input  Nkb  cipher key, big-endian [0:Nkb-1]
out_valid  output  1  plaintext available
out_ready  input  1  consumer accepts plaintext
out  output  128  plaintext block, big-endian [0:127]

Behaviour:
- Byte order: byte b occupies bits [8b +: 8]. State is column-major; column c is bytes 4c..4c+3. Round key r is w[128r +: 128], with w produced by keyexpansion from key_q.
- FSM states: IDLE, INIT, ROUND, DONE.
- Reset (rst=1 at an edge): FSM to IDLE, out_valid=0, out=0, round counter=0, key_q=0. Reset mid-transaction aborts the transaction with no output; in_ready is 1 on the first cycle after reset.
- in_ready=1 only in IDLE. out_valid=1 only in DONE.
- IDLE: on in_valid=1, capture in into state and key into key_q, then go to INIT. If in_valid=0, stay.
- INIT: state <= state ^ w[Nr]; round <= Nr-1; go to ROUND.
- ROUND, round>=1: state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), w[round])); round <= round-1.
- ROUND, round==0: final round, state <= AddRoundKey(InvSubBytes(InvShiftRows(state)), w[0]); go to DONE.
- DONE: out=state. out and out_valid stay stable until out_ready=1, then return to IDLE. in_ready rises the cycle after the output handshake; no overlap of transactions.
- Latency: if the accept happens at edge E, out_valid rises after edge E+Nr+1 (11 cycles for AES-128, 13 for AES-192, 15 for AES-256). With out_ready held high, throughput is one block per Nr+3 cycles.
- InvShiftRows: output byte (column c, row r) = input byte (column (c-r) mod 4, row r); row 0 is unshifted.
- InvSubBytes: 256-entry inverse S-box (for example 0x63->0x00, 0x7c->0x01, 0x16->0xff).
- InvMixColumns: each column is multiplied by {0e,0b,0d,09}, computed with repeated xtimes (reduction polynomial 0x11b). No general multiplier.
- key and in are ignored outside IDLE; changing them mid-transaction has no effect.
- Round counter width is 4 bits, sufficient for Nr up to 14; it never underflows because round==0 exits to DONE.

Test Plan:
1. Nk=4/Nr=10, key 000102030405060708090a0b0c0d0e0f, in 69c4e0d86a7b0430d8cdb78070b4c55a -> out 00112233445566778899aabbccddeeff; out_valid rises exactly 11 cycles after the accept edge.
2. Nk=4, key 2b7e151628aed2a6abf7158809cf4f3c, in 3925841d02dc09fbdc118597196a0b32 -> out 3243f6a8885a308d313198a2e0370734.
3. Nk=6/Nr=12, key 000102...1617, in dda97ca4864cdfe06eaf70a0ec0d7191 -> out 00112233445566778899aabbccddeeff in 13 cycles. Nk=8/Nr=14, key 000102...1e1f, in 8ea2b7ca516745bfeafc49904b496089 -> same plaintext in 15 cycles.
4. Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out stays stable and in_ready stays 0. Toggling in/key during the stall has no effect. Raising out_ready -> next cycle IDLE with in_ready=1.
5. Reset in the ROUND state at round 5 -> next cycle out_valid=0, out=0, in_ready=1. A following test-1 transaction produces the correct result.
6. Back-to-back: 3 blocks with in_valid held high and out_ready=1 -> 3 correct outputs spaced Nr+3 cycles apart, with no dropped or duplicated blocks.
